// File: rtl/sgf_norm_round.sv
// Post-multiply significand stage: normalises the 2*SW-bit product, applies the
// IEEE-754 rounding mode, post-normalises on carry and range-checks the exponent.
module sgf_norm_round #(
    parameter int SW = 24,
    parameter int EW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2*SW-1:0] product_i,
    input  logic [EW+1:0]   exp_i,
    input  logic            sign_i,
    input  logic [1:0]      rmode_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [SW-2:0]   frac_o,
    output logic [EW-1:0]   exp_o,
    output logic            overflow_o,
    output logic            underflow_o
);
    // One extra bit over the input sum absorbs the normalise and carry increments.
    localparam int XW = EW + 3;
    localparam logic signed [XW-1:0] ONE_X   = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X  = '0;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);

    typedef enum logic [2:0] {IDLE, CAPT, NORM, ROUND, POST} state_e;
    typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11} rmode_e;

    state_e               state_q;
    logic                 ready_q, done_q, ovf_q, unf_q;
    logic [SW-2:0]        frac_q;
    logic [EW-1:0]        exp_q;
    logic [2*SW-1:0]      lat_p_q, p_q;
    logic [EW+1:0]        lat_e_q;
    logic                 lat_s_q, s_q;
    rmode_e               lat_rm_q, rm_q;
    logic signed [XW-1:0] e_q;
    logic [SW-1:0]        mant_q;
    logic                 guard_q, sticky_q;
    logic                 rnd_carry_q;
    logic [SW-2:0]        rnd_frac_q;

    logic [SW-1:0]        mant_d;
    logic                 guard_d, sticky_d;
    logic signed [XW-1:0] norm_exp_d;
    logic                 inc;
    logic [SW-1:0]        frac_sum;
    logic                 rnd_carry_d;
    logic [SW-2:0]        rnd_frac_d;
    logic signed [XW-1:0] post_exp;
    logic [SW-2:0]        post_frac;
    logic [SW-2:0]        frac_d;
    logic [EW-1:0]        exp_d;
    logic                 ovf_d, unf_d;

    // NOTE: every signal written here gets a value on every path, so no latches are inferred.
    always_comb begin
        mant_d     = p_q[2*SW-2:SW-1];
        guard_d    = p_q[SW-2];
        sticky_d   = |p_q[SW-3:0];
        norm_exp_d = e_q;
        if (p_q[2*SW-1]) begin
            mant_d     = p_q[2*SW-1:SW];
            guard_d    = p_q[SW-1];
            sticky_d   = |p_q[SW-2:0];
            norm_exp_d = e_q + ONE_X;
        end
    end

    // Rounding adds into the fraction only; a carry out of the full significand
    // exists only when the hidden bit is set and the fraction wraps.
    always_comb begin
        inc = 1'b0;
        unique case (rm_q)
            RM_RNE: inc = guard_q & (sticky_q | mant_q[0]);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = ~s_q & (guard_q | sticky_q);
            RM_RDN: inc = s_q & (guard_q | sticky_q);
            default: inc = 1'b0;
        endcase
        frac_sum    = {1'b0, mant_q[SW-2:0]} + {{(SW-1){1'b0}}, inc};
        rnd_carry_d = mant_q[SW-1] & frac_sum[SW-1];
        rnd_frac_d  = frac_sum[SW-2:0];
    end

    always_comb begin
        post_exp  = rnd_carry_q ? e_q + ONE_X : e_q;
        post_frac = rnd_carry_q ? '0 : rnd_frac_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        frac_d    = '0;
        exp_d     = '0;
        if (post_exp >= EXP_MAX) begin
            ovf_d = 1'b1;
            exp_d = '1;
        end else if (post_exp <= ZERO_X) begin
            unf_d = 1'b1;
        end else begin
            frac_d = post_frac;
            exp_d  = post_exp[EW-1:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            frac_q      <= '0;
            exp_q       <= '0;
            lat_p_q     <= '0;
            lat_e_q     <= '0;
            lat_s_q     <= 1'b0;
            lat_rm_q    <= RM_RNE;
            p_q         <= '0;
            e_q         <= '0;
            s_q         <= 1'b0;
            rm_q        <= RM_RNE;
            mant_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            rnd_carry_q <= 1'b0;
            rnd_frac_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        lat_p_q  <= product_i;
                        lat_e_q  <= exp_i;
                        lat_s_q  <= sign_i;
                        lat_rm_q <= rmode_e'(rmode_i);
                        ready_q  <= 1'b0;
                        state_q  <= CAPT;
                    end
                end
                CAPT: begin
                    p_q     <= lat_p_q;
                    e_q     <= {lat_e_q[EW+1], lat_e_q};
                    s_q     <= lat_s_q;
                    rm_q    <= lat_rm_q;
                    state_q <= NORM;
                end
                NORM: begin
                    mant_q   <= mant_d;
                    guard_q  <= guard_d;
                    sticky_q <= sticky_d;
                    e_q      <= norm_exp_d;
                    state_q  <= ROUND;
                end
                ROUND: begin
                    rnd_carry_q <= rnd_carry_d;
                    rnd_frac_q  <= rnd_frac_d;
                    state_q     <= POST;
                end
                POST: begin
                    frac_q  <= frac_d;
                    exp_q   <= exp_d;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign frac_o      = frac_q;
    assign exp_o       = exp_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_sgf_norm_round.sv
// Bench for sgf_norm_round: directed corner cases, handshake/reset, then random
// operations checked against an arithmetic (quotient/remainder) rounding model.
module tb_sgf_norm_round;
    localparam int SW = 24;
    localparam int EW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2*SW-1:0] product_i;
    logic [EW+1:0]   exp_i;
    logic            sign_i;
    logic [1:0]      rmode_i;
    logic            ready_o, done_o, overflow_o, underflow_o;
    logic [SW-2:0]   frac_o;
    logic [EW-1:0]   exp_o;

    int checks = 0;
    int errors = 0;

    sgf_norm_round #(.SW(SW), .EW(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .product_i  (product_i),
        .exp_i      (exp_i),
        .sign_i     (sign_i),
        .rmode_i    (rmode_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .frac_o     (frac_o),
        .exp_o      (exp_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Value-level model: significand = P / 2^k, remainder compared against half an ulp.
    function automatic void model(input logic [2*SW-1:0] p, input int e, input bit s,
                                  input logic [1:0] rm, output logic [SW-2:0] f,
                                  output logic [EW-1:0] eo, output bit ov, output bit un);
        longint unsigned pv, scale, mant, rem, half;
        int shift, ex;
        bit up;
        pv    = 64'(p);
        shift = (pv >= (64'd1 << (2*SW-1))) ? 1 : 0;
        scale = 64'd1 << (SW - 1 + shift);
        mant  = pv / scale;
        rem   = pv % scale;
        half  = scale / 2;
        case (rm)
            2'b00:   up = (rem > half) || (rem == half && (mant % 2) == 1);
            2'b01:   up = 1'b0;
            2'b10:   up = !s && rem != 0;
            default: up = s && rem != 0;
        endcase
        mant = mant + 64'(up);
        ex   = e + shift;
        if (mant == (64'd1 << SW)) begin
            mant = mant / 2;
            ex++;
        end
        f  = '0;
        eo = '0;
        ov = 1'b0;
        un = 1'b0;
        if (ex >= (1 << EW) - 1) begin
            ov = 1'b1;
            eo = '1;
        end else if (ex <= 0) begin
            un = 1'b1;
        end else begin
            f  = (SW-1)'(mant - (64'd1 << (SW-1)));
            eo = EW'(ex);
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the done cycle.
    task automatic run_op(input string tag, input logic [2*SW-1:0] p, input int e,
                          input bit s, input logic [1:0] rm);
        logic [SW-2:0] ef;
        logic [EW-1:0] ee;
        bit            eov, eun;
        int            lat;
        bit            busy_ok;
        model(p, e, s, rm, ef, ee, eov, eun);
        product_i = p;
        exp_i     = (EW+2)'(e);
        sign_i    = s;
        rmode_i   = rm;
        start_i   = 1'b1;
        lat       = 0;
        busy_ok   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start_i = 1'b0;
            if (done_o) begin
                lat = i;
                break;
            end
            if (ready_o) busy_ok = 1'b0;
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " ready low while busy"}, 32'(busy_ok), 1);
        check({tag, " ready in done cycle"}, 32'(ready_o), 1);
        check({tag, " frac"}, 32'(frac_o), 32'(ef));
        check({tag, " exp"}, 32'(exp_o), 32'(ee));
        check({tag, " overflow"}, 32'(overflow_o), 32'(eov));
        check({tag, " underflow"}, 32'(underflow_o), 32'(eun));
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done_o), 0);
        check({tag, " frac held"}, 32'(frac_o), 32'(ef));
    endtask

    initial begin
        logic [2*SW-1:0] p;
        bit              seen;
        rst       = 1'b1;
        start_i   = 1'b0;
        product_i = '0;
        exp_i     = '0;
        sign_i    = 1'b0;
        rmode_i   = 2'b00;
        #12;
        check("reset ready", 32'(ready_o), 1);
        check("reset done", 32'(done_o), 0);
        check("reset frac", 32'(frac_o), 0);
        check("reset exp", 32'(exp_o), 0);
        check("reset flags", {30'd0, overflow_o, underflow_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases; expected values from the model are cross-checked with constants.
        run_op("one", 48'h4000_0000_0000, 127, 1'b0, 2'b00);
        check("one frac const", 32'(frac_o), 0);
        check("one exp const", 32'(exp_o), 127);
        run_op("1.5sq", 48'h9000_0000_0000, 127, 1'b0, 2'b00);
        check("1.5sq frac const", 32'(frac_o), 32'h100000);
        check("1.5sq exp const", 32'(exp_o), 128);
        run_op("carry rne", 48'h7FFF_FFFF_FFFF, 100, 1'b0, 2'b00);
        check("carry rne const", {frac_o, exp_o}, {23'd0, 8'd101});
        run_op("carry rtz", 48'h7FFF_FFFF_FFFF, 100, 1'b0, 2'b01);
        check("carry rtz const", {frac_o, exp_o}, {23'h7FFFFF, 8'd100});
        run_op("tie rne", 48'h4000_0040_0000, 127, 1'b0, 2'b00);
        check("tie rne const", 32'(frac_o), 0);
        run_op("tie rup", 48'h4000_0040_0000, 127, 1'b0, 2'b10);
        check("tie rup const", 32'(frac_o), 1);
        run_op("tie rdn", 48'h4000_0040_0000, 127, 1'b0, 2'b11);
        check("tie rdn const", 32'(frac_o), 0);
        run_op("tie rdn neg", 48'h4000_0040_0000, 127, 1'b1, 2'b11);
        run_op("ovf", 48'h9000_0000_0000, 254, 1'b0, 2'b00);
        check("ovf const", {overflow_o, exp_o, frac_o}, {1'b1, 8'hFF, 23'd0});
        run_op("unf zero", 48'h4000_0000_0000, 0, 1'b0, 2'b00);
        check("unf zero const", {underflow_o, exp_o, frac_o}, {1'b1, 8'h00, 23'd0});
        run_op("unf neg", 48'h4000_0000_0000, -5, 1'b0, 2'b00);
        run_op("edge 253", 48'h9000_0000_0000, 253, 1'b1, 2'b01);

        // start_i held high: one result every 5 cycles, ready only in done cycles.
        product_i = 48'h9000_0000_0000;
        exp_i     = 10'd127;
        sign_i    = 1'b0;
        rmode_i   = 2'b00;
        start_i   = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check($sformatf("held done c%0d", c), 32'(done_o), 32'(c % 5 == 0));
            check($sformatf("held ready c%0d", c), 32'(ready_o), 32'(c % 5 == 0));
        end
        start_i = 1'b0;
        @(negedge clk);

        // Reset asserted while the operation is in ROUND.
        run_op("pre reset", 48'h9000_0000_0000, 127, 1'b0, 2'b00);
        product_i = 48'h7FFF_FFFF_FFFF;
        exp_i     = 10'd100;
        start_i   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) start_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midop reset ready", 32'(ready_o), 1);
        check("midop reset outputs", {9'd0, frac_o}, 0);
        check("midop reset exp", 32'(exp_o), 0);
        @(negedge clk);
        rst = 1'b0;
        check("after reset ready", 32'(ready_o), 1);
        check("after reset done", 32'(done_o), 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("aborted op no done", 32'(seen), 0);
        run_op("post reset", 48'h7FFF_FFFF_FFFF, 100, 1'b0, 2'b01);

        // Random operations, biased toward ties and rounding carries.
        for (int n = 0; n < 150; n++) begin
            int k;
            p = {16'($urandom), 32'($urandom)};
            k = int'($urandom_range(0, 3));
            if (k == 1) p[22:0] = 23'h400000;
            if (k == 2) p[23:0] = 24'h800000;
            if (k == 3) p[46:22] = '1;
            if (p[47:46] == 2'b00) p[46] = 1'b1;
            run_op($sformatf("rand%0d", n), p, int'($urandom_range(0, 275)) - 10,
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgf_norm_round.md
Name: sgf_norm_round

Overview:
- Post-multiply stage of the FPU significand datapath.
- Consumes the registered 2*SW-bit significand product from the Karatsuba multiplier's output register, together with the pre-computed biased exponent sum and sign.
- Normalises the product, applies the IEEE-754 rounding mode, post-normalises on rounding carry, and flags overflow/underflow.
- A 4-state-per-operation FSM gives fixed latency with a start/ready/done handshake; the result feeds the final FP packer.

Parameters:
- SW, 24, significand width including hidden bit (24 single, 53 double); product is 2*SW bits.
- EW, 8, exponent field width (8 single, 11 double).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  product/exponent valid; sampled only when ready_o=1.
- product_i  in  2*SW  unsigned significand product, value in [1,4) scaled by 2^(2SW-2).
- exp_i  in  EW+2  two's-complement biased exponent sum (ea+eb-bias).
- sign_i  in  1  result sign.
- rmode_i  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse, result valid.
- frac_o  out  SW-1  rounded fraction, hidden bit removed.
- exp_o  out  EW  final biased exponent.
- overflow_o  out  1  result overflowed.
- underflow_o  out  1  result underflowed and was flushed to zero.

Behaviour:
- Reset (asynchronous): state=IDLE; ready_o=1; done_o, frac_o, exp_o, overflow_o, underflow_o=0. Reset mid-operation aborts the operation with no done_o.
- States: IDLE -> CAPT -> NORM -> ROUND -> POST -> IDLE.
- IDLE: on start_i=1, latch product_i, exp_i, sign_i, rmode_i; go to CAPT. start_i is ignored in every other state; no queueing.
- CAPT -> NORM (unconditional): register the latched operands.
- NORM:
  - If P[2SW-1]=1: mant=P[2SW-1:SW], guard=P[SW-1], sticky=|P[SW-2:0], exp=exp+1.
  - Else: mant=P[2SW-2:SW-1], guard=P[SW-2], sticky=|P[SW-3:0].
- ROUND: inc = RNE: guard&(sticky|mant[0]); RTZ: 0; RUP: ~sign&(guard|sticky); RDN: sign&(guard|sticky). mant_r = mant+inc, computed SW+1 bits wide.
- POST:
  - If mant_r[SW]=1 (carry): frac=0, exp=exp+1; else frac=mant_r[SW-2:0].
  - Range check on the signed exponent:
    - exp >= 2^EW-1: overflow_o=1, exp_o all ones, frac_o=0.
    - exp <= 0: underflow_o=1, exp_o=0, frac_o=0. No subnormals.
    - Otherwise flags=0 and outputs take exp/frac.
  - Outputs register on the POST->IDLE edge; done_o=1 for exactly that following cycle, in which ready_o is already 1.
- Latency: start_i sampled at edge 0; done_o high in the cycle after edge 4. Back-to-back throughput is one operation per 5 cycles when start_i is re-asserted in the done cycle.
- Outputs hold their last value until the next completed operation. Flags are updated, not sticky.
- A product with both top bits 0 (invalid input) is treated as the else-branch with no detection.

Test Plan (SW=24, EW=8):
- product 0x4000_0000_0000, exp_i=127, RNE -> done_o after 5 cycles, frac_o=0, exp_o=127, flags 0.
- product 0x9000_0000_0000 (1.5*1.5), exp_i=127 -> frac_o=0x100000, exp_o=128.
- product 0x7FFF_FFFF_FFFF, exp_i=100, RNE -> rounding carry: frac_o=0, exp_o=101. Same stimulus with RTZ -> frac_o=0x7FFFFF, exp_o=100.
- Tie product 0x4000_0040_0000, exp_i=127:
  - RNE -> frac_o=0.
  - RUP, sign 0 -> frac_o=1.
  - RDN, sign 0 -> frac_o=0.
- Range:
  - 0x9000_0000_0000 with exp_i=254 -> overflow_o=1, exp_o=0xFF, frac_o=0.
  - 0x4000_0000_0000 with exp_i=0 -> underflow_o=1, all zero.
  - exp_i=-5 -> underflow_o=1.
- Handshake/reset:
  - start_i held high continuously -> one operation per 5 cycles, ready_o low during CAPT..POST.
  - rst pulsed in ROUND -> no done_o, outputs 0, ready_o=1 on the next cycle.
